// File: rtl/ahblite_m_port_gen.sv
// AHB-Lite master port generator: decodes the master address phase onto one of
// SLV_NUM slave ports, requests that slave, waits for its grant and then returns
// the owning slave's response to the master. Address-phase outputs are registered.
// Optional feature: define AHBLITE_M_PORT_GEN_ERR_SLAVE_EN to add a default slave
// that answers unmapped NONSEQ transfers with a two-cycle ERROR response; without
// it, unmapped transfers complete as zero-wait OKAY.
module ahblite_m_port_gen #(
    parameter int unsigned AHB_AW  = 32,
    parameter int unsigned AHB_DW  = 32,
    parameter int unsigned SLV_NUM = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    // AHB-Lite master side
    input  logic [AHB_AW-1:0]           haddr_i,
    input  logic                        hwrite_i,
    input  logic [1:0]                  htrans_i,
    input  logic [2:0]                  hsize_i,
    input  logic [2:0]                  hburst_i,
    input  logic [3:0]                  hprot_i,
    input  logic [AHB_DW-1:0]           hwdata_i,
    input  logic                        hmastlock_i,
    output logic                        hreadyout_o,
    output logic                        hresp_o,
    output logic [AHB_DW-1:0]           hrdata_o,
    // Slave address map, slave k occupies bits [k*AHB_AW +: AHB_AW]
    input  logic [SLV_NUM*AHB_AW-1:0]   s_addr_base_i,
    input  logic [SLV_NUM*AHB_AW-1:0]   s_addr_mask_i,
    // Slave side
    output logic [SLV_NUM-1:0]          s_req_o,
    input  logic [SLV_NUM-1:0]          s_grant_i,
    output logic [AHB_AW-1:0]           s_haddr_o,
    output logic                        s_hwrite_o,
    output logic [1:0]                  s_htrans_o,
    output logic [2:0]                  s_hsize_o,
    output logic [2:0]                  s_hburst_o,
    output logic [3:0]                  s_hprot_o,
    output logic                        s_hmastlock_o,
    output logic [AHB_DW-1:0]           s_hwdata_o,
    input  logic [SLV_NUM-1:0]          s_hready_i,
    input  logic [SLV_NUM-1:0]          s_hresp_i,
    input  logic [SLV_NUM*AHB_DW-1:0]   s_hrdata_i,
    output logic                        s_hreadyout_o
);

    localparam logic [1:0]         TransNonseq = 2'b10;
    localparam logic [SLV_NUM-1:0] SlvOne      = SLV_NUM'(1);

    typedef enum logic [1:0] {
        StIdle,
        StWaitGnt,
`ifdef AHBLITE_M_PORT_GEN_ERR_SLAVE_EN
        StOwn,
        StErr
`else
        StOwn
`endif
    } state_e;

    state_e               state_q;
    logic [SLV_NUM-1:0]   req_q;
    logic [SLV_NUM-1:0]   owner_q;
`ifdef AHBLITE_M_PORT_GEN_ERR_SLAVE_EN
    logic                 err_ph_q;   // 0: first ERROR cycle, 1: second
`endif

    logic [SLV_NUM-1:0]   match;
    logic [SLV_NUM-1:0]   sel;
    logic                 mapped;
    logic                 accept;
    state_e               acc_state;
    logic [SLV_NUM-1:0]   acc_req;
    logic [SLV_NUM-1:0]   acc_owner;

    // Address decode; lowest matching index wins via isolate-lowest-set-bit.
    always_comb begin
        match = '0;
        for (int k = 0; k < SLV_NUM; k++) begin
            match[k] = ((haddr_i ^ s_addr_base_i[k*AHB_AW +: AHB_AW])
                        & s_addr_mask_i[k*AHB_AW +: AHB_AW]) == '0;
        end
        sel    = match & (~match + SlvOne);
        mapped = |sel;
        accept = (htrans_i == TransNonseq) && hreadyout_o;
    end

    // Next FSM values for an accepted address phase, shared by every accepting state.
    always_comb begin
        acc_state = StIdle;
        acc_req   = '0;
        acc_owner = '0;
        if (mapped) begin
            if (|(s_grant_i & sel)) begin
                // Grant already present: skip the request register entirely.
                acc_state = StOwn;
                acc_owner = sel;
            end else begin
                acc_state = StWaitGnt;
                acc_req   = sel;
            end
        end else begin
`ifdef AHBLITE_M_PORT_GEN_ERR_SLAVE_EN
            acc_state = StErr;
`else
            acc_state = StIdle;
`endif
        end
    end

    // Master response mux, selected by FSM state and the one-hot owner.
    always_comb begin
        hreadyout_o = 1'b1;
        hresp_o     = 1'b0;
        hrdata_o    = '0;
        unique case (state_q)
            StIdle: begin
                hreadyout_o = 1'b1;
            end
            StWaitGnt: begin
                hreadyout_o = 1'b0;
            end
            StOwn: begin
                for (int k = 0; k < SLV_NUM; k++) begin
                    if (owner_q[k]) begin
                        hreadyout_o = s_hready_i[k];
                        hresp_o     = s_hresp_i[k];
                        hrdata_o    = s_hrdata_i[k*AHB_DW +: AHB_DW];
                    end
                end
            end
`ifdef AHBLITE_M_PORT_GEN_ERR_SLAVE_EN
            StErr: begin
                hreadyout_o = err_ph_q;
                hresp_o     = 1'b1;
            end
`endif
            default: begin
                hreadyout_o = 1'b1;
            end
        endcase
    end

    // Request is combinational in the accept cycle, registered while waiting for grant.
    always_comb begin
        s_req_o = req_q;
        if (accept && mapped && !(|(s_grant_i & sel))) begin
            s_req_o = req_q | sel;
        end else if (accept && mapped) begin
            s_req_o = req_q | sel;
        end
        s_hreadyout_o = hreadyout_o;
    end

    // Transfer FSM with request and owner registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            req_q    <= '0;
            owner_q  <= '0;
`ifdef AHBLITE_M_PORT_GEN_ERR_SLAVE_EN
            err_ph_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StWaitGnt: begin
                    // Only the grant of the requested slave matters.
                    if (|(s_grant_i & req_q)) begin
                        state_q <= StOwn;
                        owner_q <= req_q;
                        req_q   <= '0;
                    end
                end
`ifdef AHBLITE_M_PORT_GEN_ERR_SLAVE_EN
                StErr: begin
                    if (!err_ph_q) begin
                        err_ph_q <= 1'b1;
                    end else begin
                        // Second ERROR cycle completes the beat; a new NONSEQ may follow.
                        state_q  <= accept ? acc_state : StIdle;
                        req_q    <= accept ? acc_req : '0;
                        owner_q  <= accept ? acc_owner : '0;
                        err_ph_q <= 1'b0;
                    end
                end
`endif
                default: begin
                    // StIdle and StOwn: act only when the current beat completes.
                    if (hreadyout_o) begin
                        state_q <= accept ? acc_state : StIdle;
                        req_q   <= accept ? acc_req : '0;
                        owner_q <= accept ? acc_owner : '0;
`ifdef AHBLITE_M_PORT_GEN_ERR_SLAVE_EN
                        err_ph_q <= 1'b0;
`endif
                    end
                end
            endcase
        end
    end

    // Registered address phase and write data, loaded whenever the master bus is ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_haddr_o     <= '0;
            s_hwrite_o    <= 1'b0;
            s_htrans_o    <= '0;
            s_hsize_o     <= '0;
            s_hburst_o    <= '0;
            s_hprot_o     <= '0;
            s_hmastlock_o <= 1'b0;
            s_hwdata_o    <= '0;
        end else if (hreadyout_o) begin
            s_haddr_o     <= haddr_i;
            s_hwrite_o    <= hwrite_i;
            s_htrans_o    <= htrans_i;
            s_hsize_o     <= hsize_i;
            s_hburst_o    <= hburst_i;
            s_hprot_o     <= hprot_i;
            s_hmastlock_o <= hmastlock_i;
            s_hwdata_o    <= hwdata_i;
        end
    end

endmodule

// File: tb/tb_ahblite_m_port_gen.sv
// Directed, table-driven bench for ahblite_m_port_gen (default 32/32/8 configuration).
// Expectations for unmapped transfers follow AHBLITE_M_PORT_GEN_ERR_SLAVE_EN.
module tb_ahblite_m_port_gen;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned NS = 8;

`ifdef AHBLITE_M_PORT_GEN_ERR_SLAVE_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [AW-1:0]     haddr;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
    logic [DW-1:0]     hwdata;
    logic              hmastlock;
    logic              hreadyout_o;
    logic              hresp_o;
    logic [DW-1:0]     hrdata_o;
    logic [NS*AW-1:0]  s_base;
    logic [NS*AW-1:0]  s_mask;
    logic [NS-1:0]     s_req_o;
    logic [NS-1:0]     s_grant;
    logic [AW-1:0]     s_haddr_o;
    logic              s_hwrite_o;
    logic [1:0]        s_htrans_o;
    logic [2:0]        s_hsize_o;
    logic [2:0]        s_hburst_o;
    logic [3:0]        s_hprot_o;
    logic              s_hmastlock_o;
    logic [DW-1:0]     s_hwdata_o;
    logic [NS-1:0]     s_hready;
    logic [NS-1:0]     s_hresp;
    logic [NS*DW-1:0]  s_hrdata;
    logic              s_hreadyout_o;

    int n_vec  = 0;
    int n_miss = 0;

    ahblite_m_port_gen #(
        .AHB_AW  (AW),
        .AHB_DW  (DW),
        .SLV_NUM (NS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .haddr_i       (haddr),
        .hwrite_i      (hwrite),
        .htrans_i      (htrans),
        .hsize_i       (hsize),
        .hburst_i      (hburst),
        .hprot_i       (hprot),
        .hwdata_i      (hwdata),
        .hmastlock_i   (hmastlock),
        .hreadyout_o   (hreadyout_o),
        .hresp_o       (hresp_o),
        .hrdata_o      (hrdata_o),
        .s_addr_base_i (s_base),
        .s_addr_mask_i (s_mask),
        .s_req_o       (s_req_o),
        .s_grant_i     (s_grant),
        .s_haddr_o     (s_haddr_o),
        .s_hwrite_o    (s_hwrite_o),
        .s_htrans_o    (s_htrans_o),
        .s_hsize_o     (s_hsize_o),
        .s_hburst_o    (s_hburst_o),
        .s_hprot_o     (s_hprot_o),
        .s_hmastlock_o (s_hmastlock_o),
        .s_hwdata_o    (s_hwdata_o),
        .s_hready_i    (s_hready),
        .s_hresp_i     (s_hresp),
        .s_hrdata_i    (s_hrdata),
        .s_hreadyout_o (s_hreadyout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       nm;
        logic        rs;
        logic [1:0]  tr;
        logic [31:0] ad;
        logic [7:0]  gr;
        logic [7:0]  rd;
        logic [7:0]  e_req;
        logic        e_rdy;
        logic        e_resp;
        logic [31:0] e_rdata;
        logic [31:0] e_saddr;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input string nm, input logic rs, input logic [1:0] tr,
                        input logic [31:0] ad, input logic [7:0] gr, input logic [7:0] rd,
                        input logic [7:0] e_req, input logic e_rdy, input logic e_resp,
                        input logic [31:0] e_rdata, input logic [31:0] e_saddr);
        vec_t v;
        v.nm = nm; v.rs = rs; v.tr = tr; v.ad = ad; v.gr = gr; v.rd = rd;
        v.e_req = e_req; v.e_rdy = e_rdy; v.e_resp = e_resp;
        v.e_rdata = e_rdata; v.e_saddr = e_saddr;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input string f, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s.%s: got %h, expected %h", nm, f, act, exp);
        end
    endtask

    initial begin
        int n;
        bit done;

        // Address map: 0 @0x0000_xxxx, 1 @0x40xx_xxxx, 2 @0x2000_xxxx,
        // 3 @0x4xxx_xxxx (overlaps 1), 5 @0x5000_xxxx; others unreachable.
        for (int k = 0; k < NS; k++) begin
            s_base[k*AW +: AW]   = 32'hE000_0000 + k;
            s_mask[k*AW +: AW]   = 32'hFFFF_FFFF;
            s_hrdata[k*DW +: DW] = 32'hD000_0000 + k;
        end
        s_base[0*AW +: AW] = 32'h0000_0000; s_mask[0*AW +: AW] = 32'hFFFF_0000;
        s_base[1*AW +: AW] = 32'h4000_0000; s_mask[1*AW +: AW] = 32'hFF00_0000;
        s_base[2*AW +: AW] = 32'h2000_0000; s_mask[2*AW +: AW] = 32'hFFFF_0000;
        s_base[3*AW +: AW] = 32'h4000_0000; s_mask[3*AW +: AW] = 32'hF000_0000;
        s_base[5*AW +: AW] = 32'h5000_0000; s_mask[5*AW +: AW] = 32'hFFFF_0000;

        rst = 1'b1; haddr = '0; hwrite = 1'b0; htrans = 2'b00; hsize = 3'd2;
        hburst = '0; hprot = 4'h3; hwdata = '0; hmastlock = 1'b0;
        s_grant = '0; s_hready = 8'hFF; s_hresp = '0;

        //   name        rs tr     addr          gnt    rdy    req   rdy resp rdata         saddr
        addv("reset",    0, 2'b00, 32'h0,        8'h00, 8'hFF, 8'h00, 1, 0, 32'h0,        32'h0);
        addv("r29_req",  0, 2'b10, 32'h2000_0010, 8'h00, 8'hFF, 8'h04, 1, 0, 32'h0,        32'h0);
        addv("r29_w1",   0, 2'b00, 32'h0,        8'h00, 8'hFF, 8'h04, 0, 0, 32'h0,        32'h2000_0010);
        addv("r29_w2",   0, 2'b00, 32'h0,        8'h00, 8'hFF, 8'h04, 0, 0, 32'h0,        32'h2000_0010);
        addv("r29_w3",   0, 2'b00, 32'h0,        8'h04, 8'hFF, 8'h04, 0, 0, 32'h0,        32'h2000_0010);
        addv("r29_data", 0, 2'b00, 32'h0,        8'h00, 8'hFF, 8'h00, 1, 0, 32'hD000_0002, 32'h2000_0010);
        addv("r29_idle", 0, 2'b00, 32'h0,        8'h00, 8'hFF, 8'h00, 1, 0, 32'h0,        32'h0);
        addv("r30_acc",  0, 2'b10, 32'h9000_0000, 8'h00, 8'hFF, 8'h00, 1, 0, 32'h0,        32'h0);
        addv("r30_c1",   0, 2'b00, 32'h0,        8'h00, 8'hFF, 8'h00, !ErrEn, ErrEn, 32'h0, 32'h9000_0000);
        addv("r30_c2",   0, 2'b00, 32'h0,        8'h00, 8'hFF, 8'h00, 1, ErrEn, 32'h0,
             ErrEn ? 32'h9000_0000 : 32'h0);
        addv("r30_idle", 0, 2'b00, 32'h0,        8'h00, 8'hFF, 8'h00, 1, 0, 32'h0,        32'h0);
        addv("r31_req",  0, 2'b10, 32'h4000_0000, 8'h02, 8'hFF, 8'h02, 1, 0, 32'h0,        32'h0);
        addv("r32_own",  0, 2'b00, 32'h0,        8'h08, 8'hFD, 8'h00, 0, 0, 32'hD000_0001, 32'h4000_0000);
        addv("r32_done", 0, 2'b00, 32'h0,        8'h00, 8'hFF, 8'h00, 1, 0, 32'hD000_0001, 32'h4000_0000);
        addv("r34_a",    0, 2'b10, 32'h0000_0100, 8'h01, 8'hFF, 8'h01, 1, 0, 32'h0,        32'h0);
        addv("r34_b",    0, 2'b10, 32'h5000_0040, 8'h00, 8'hFF, 8'h20, 1, 0, 32'hD000_0000, 32'h0000_0100);
        addv("r34_w",    0, 2'b00, 32'h0,        8'h20, 8'hFF, 8'h20, 0, 0, 32'h0,        32'h5000_0040);
        addv("r34_d",    0, 2'b00, 32'h0,        8'h00, 8'hFF, 8'h00, 1, 0, 32'hD000_0005, 32'h5000_0040);
        addv("r33_req",  0, 2'b10, 32'h2000_0000, 8'h00, 8'hFF, 8'h04, 1, 0, 32'h0,        32'h0);
        addv("r33_w",    0, 2'b00, 32'h0,        8'h00, 8'hFF, 8'h04, 0, 0, 32'h0,        32'h2000_0000);
        addv("r33_rst",  1, 2'b00, 32'h0,        8'h00, 8'hFF, 8'h04, 0, 0, 32'h0,        32'h2000_0000);
        addv("r33_post", 0, 2'b00, 32'h0,        8'h00, 8'hFF, 8'h00, 1, 0, 32'h0,        32'h0);
        addv("idle_seq", 0, 2'b11, 32'h2000_0000, 8'h00, 8'hFF, 8'h00, 1, 0, 32'h0,        32'h0);
        addv("seq_held", 0, 2'b00, 32'h0,        8'h00, 8'hFF, 8'h00, 1, 0, 32'h0,        32'h2000_0000);

        repeat (2) @(posedge clk);

        foreach (vq[i]) begin
            @(negedge clk);
            rst = vq[i].rs; htrans = vq[i].tr; haddr = vq[i].ad;
            s_grant = vq[i].gr; s_hready = vq[i].rd;
            #2;
            chk(vq[i].nm, "s_req",   32'(s_req_o),     32'(vq[i].e_req));
            chk(vq[i].nm, "hready",  32'(hreadyout_o), 32'(vq[i].e_rdy));
            chk(vq[i].nm, "hresp",   32'(hresp_o),     32'(vq[i].e_resp));
            chk(vq[i].nm, "hrdata",  hrdata_o,         vq[i].e_rdata);
            chk(vq[i].nm, "s_haddr", s_haddr_o,        vq[i].e_saddr);
            chk(vq[i].nm, "s_hrdyo", 32'(s_hreadyout_o), 32'(vq[i].e_rdy));
        end

        // Write to slave 5 with a late grant: five wait cycles, write data held,
        // slave ERROR response passed through on completion.
        @(negedge clk);
        rst = 1'b0; htrans = 2'b10; haddr = 32'h5000_0000; hwrite = 1'b1;
        hwdata = 32'h0000_0011; s_grant = '0; s_hready = 8'hFF;
        #2;
        chk("wr_req", "s_req", 32'(s_req_o), 32'h20);
        n = 0;
        done = 1'b0;
        while (!done && n < 20) begin
            @(negedge clk);
            htrans = 2'b00; haddr = '0; hwrite = 1'b0; hwdata = 32'h0000_0022;
            s_grant = (n == 4) ? 8'h20 : 8'h00;
            s_hresp = (n == 5) ? 8'h20 : 8'h00;
            #2;
            if (hreadyout_o) done = 1'b1;
            else n++;
        end
        chk("wr_wait", "done",     32'(done),       32'd1);
        chk("wr_wait", "cycles",   32'(n),          32'd5);
        chk("wr_data", "hresp",    32'(hresp_o),    32'd1);
        chk("wr_data", "hrdata",   hrdata_o,        32'hD000_0005);
        chk("wr_data", "s_hwdata", s_hwdata_o,      32'h0000_0011);
        chk("wr_data", "s_hwrite", 32'(s_hwrite_o), 32'd1);
        chk("wr_data", "s_haddr",  s_haddr_o,       32'h5000_0000);
        @(negedge clk);
        s_grant = '0; s_hresp = '0;
        #2;
        chk("wr_end", "hready",   32'(hreadyout_o), 32'd1);
        chk("wr_end", "hresp",    32'(hresp_o),     32'd0);
        chk("wr_end", "s_hwdata", s_hwdata_o,       32'h0000_0022);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ahblite_m_port_gen.md
AHBLITE_M_PORT_GEN -- requirements
Module: ahblite_m_port_gen

Interface
REQ-001 Parameter AHB_AW, default 32: address width.
REQ-002 Parameter AHB_DW, default 32: data width.
REQ-003 Parameter SLV_NUM, default 8: number of slave ports, range 1..16.
REQ-004 Port clk  in  1: single clock; all state SHALL update on its rising edge.
REQ-005 Port rst  in  1: reset, synchronous and active-high.
REQ-006 Ports from the AHB-Lite master SHALL be:
- haddr_i (AHB_AW), hwrite_i (1), htrans_i (2), hsize_i (3), hburst_i (3), hprot_i (4), hwdata_i (AHB_DW), hmastlock_i (1): all in.
- hreadyout_o (1), hresp_o (1), hrdata_o (AHB_DW): all out.
REQ-007 Port s_addr_base_i  in  SLV_NUM x AHB_AW: base address per slave.
REQ-008 Port s_addr_mask_i  in  SLV_NUM x AHB_AW: compare mask per slave; 1 = bit compared.
REQ-009 Port s_req_o  out  SLV_NUM: request per slave.
REQ-010 Port s_grant_i  in  SLV_NUM: one-hot grant per slave.
REQ-011 Ports s_haddr_o, s_hwrite_o, s_htrans_o, s_hsize_o, s_hburst_o, s_hprot_o, s_hmastlock_o  out: registered address phase, widths as REQ-006. Port s_hwdata_o  out  AHB_DW.
REQ-012 Port s_hready_i  in  SLV_NUM, s_hresp_i  in  SLV_NUM, s_hrdata_i  in  SLV_NUM x AHB_DW: per-slave responses.
REQ-013 Port s_hreadyout_o  out  1: copy of hreadyout_o.

Function
REQ-014 Slave k SHALL match when ((haddr_i ^ s_addr_base_i[k]) & s_addr_mask_i[k]) == 0. If several slaves match, the lowest index SHALL win. No match SHALL be flagged as unmapped.
REQ-015 The address phase SHALL be accepted only when htrans_i is NONSEQ (2'b10) and hreadyout_o is 1.
REQ-016 Every address-phase output SHALL load from its input when hreadyout_o is 1, and SHALL hold otherwise. s_hwdata_o SHALL follow the same rule.
REQ-017 The FSM SHALL have four states: IDLE, WAIT_GNT, OWN, ERR.
REQ-018 IDLE, mapped accept: s_req_o[k] SHALL assert combinationally in the same cycle, then stay registered. Next state SHALL be WAIT_GNT, or OWN if s_grant_i[k] is already 1.
REQ-019 WAIT_GNT: s_req_o[k] SHALL hold; hreadyout_o SHALL be 0 and hresp_o 0. On s_grant_i[k] the request SHALL clear and the next state SHALL be OWN.
REQ-020 OWN: a one-hot owner register (owner[k]=1) SHALL select hreadyout_o, hresp_o and hrdata_o from slave k. A grant on any other slave SHALL be ignored.
REQ-021 OWN, when s_hready_i[k]=1:
- new mapped accept SHALL go to REQ-018 handling;
- unmapped accept SHALL go to ERR;
- otherwise the next state SHALL be IDLE.
REQ-022 IDLE or OWN, unmapped accept (default slave): ERR SHALL give a two-cycle ERROR response.
- Cycle 1: hreadyout_o=0, hresp_o=1.
- Cycle 2: hreadyout_o=1, hresp_o=1.
- Then IDLE.
- hrdata_o SHALL be 0 in ERR.
REQ-023 IDLE with no accept (IDLE/BUSY/SEQ): hreadyout_o SHALL be 1, hresp_o 0 and hrdata_o 0.
REQ-024 Only one request SHALL be outstanding at a time; s_req_o SHALL be zero or one-hot.
REQ-025 A grant in the same cycle as the request SHALL take precedence: the request SHALL not be registered.

Reset
REQ-026 While rst=1 the following SHALL clear at the next clock edge:
- FSM to IDLE, owner to 0, s_req_o to 0, all registered s_* outputs to 0;
- hreadyout_o=1, hresp_o=0, hrdata_o=0.
REQ-027 Reset mid-transfer (WAIT_GNT, OWN or ERR) SHALL abort without a completion beat; the master SHALL see hreadyout_o=1 on the cycle after reset.

Configuration
REQ-028 Macro AHBLITE_M_PORT_GEN_ERR_SLAVE_EN.
- Defined: REQ-022 default-slave ERROR behaviour applies.
- Undefined: the ERR state SHALL not exist; unmapped accepts SHALL complete as zero-wait OKAY (hreadyout_o=1, hresp_o=0, hrdata_o=0) and s_req_o SHALL stay 0.

Verification
REQ-029 Slave 2 base 0x2000_0000, mask 0xFFFF_0000; NONSEQ read 0x2000_0010; grant 3 cycles later; s_hready_i[2]=1 -> s_req_o=0x04 until grant, hreadyout_o=0 for 3 cycles, then hrdata_o=s_hrdata_i[2].
REQ-030 NONSEQ 0x9000_0000 unmapped, macro defined -> hreadyout_o/hresp_o = 0/1 then 1/1, then IDLE; macro undefined -> 1/0 immediately.
REQ-031 Slaves 1 and 3 both match 0x4000_0000 -> only s_req_o[1] asserts.
REQ-032 Request and grant in the same cycle -> s_req_o pulses one cycle, FSM goes directly to OWN.
REQ-033 rst=1 while in WAIT_GNT -> next cycle s_req_o=0, hreadyout_o=1, s_haddr_o=0.
REQ-034 Back-to-back NONSEQs to slave 0 then slave 5 with s_hready_i[0]=1 -> the second request issues in the first transfer's data phase and hrdata_o switches owner cleanly.
